// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory.
// The controller takes the master view; the datapath side takes the slave view.
interface mips_multicycle_controller_if #(
  parameter int INSTR_WIDTH    = 32,
  parameter int ALU_CTRL_WIDTH = 3
);
  logic [INSTR_WIDTH-1:0]    instr;
  logic                      zero;
  logic                      mem_ready;
  logic                      mem_req;
  logic                      memwrite;
  logic                      iord;
  logic                      irwrite;
  logic                      pcen;
  logic [1:0]                pcsrc;
  logic                      alusrca;
  logic [1:0]                alusrcb;
  logic                      zeroext;
  logic                      regwrite;
  logic                      regdst;
  logic                      memtoreg;
  logic [ALU_CTRL_WIDTH-1:0] alucontrol;
  logic                      illegal;
  logic                      mem_err;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           zeroext, regwrite, regdst, memtoreg, alucontrol, illegal, mem_err
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           zeroext, regwrite, regdst, memtoreg, alucontrol, illegal, mem_err
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// against a variable-latency memory, with illegal-opcode and memory-timeout pulses.
module mips_multicycle_controller #(
  parameter int INSTR_WIDTH    = 32,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int EN_EXT         = 1,
  parameter int MEM_TIMEOUT    = 16
) (
  input  logic clk,
  input  logic rst,
  mips_multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW   = 6'b101011,
                         OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_SLTI = 6'b001010,
                         OP_J     = 6'b000010;
  localparam logic [5:0] F_NOP = 6'b000000, F_ADD = 6'b100000, F_SUB = 6'b100010,
                         F_AND = 6'b100100, F_OR  = 6'b100101, F_SLT = 6'b101010;
  localparam bit EXT = (EN_EXT != 0);
  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      F_SUB:   r_alu = 3'b110;
      F_AND:   r_alu = 3'b000;
      F_OR:    r_alu = 3'b001;
      F_SLT:   r_alu = 3'b111;
      default: r_alu = 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] o);
    case (o)
      OP_ANDI: i_alu = 3'b000;
      OP_ORI:  i_alu = 3'b001;
      OP_SLTI: i_alu = 3'b111;
      default: i_alu = 3'b010;
    endcase
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             mem_state, tmo;

  logic [5:0] op, funct;
  logic       unused_instr;
  assign op           = bus.instr[INSTR_WIDTH-1 -: 6];
  assign funct        = bus.instr[5:0];
  assign unused_instr = ^bus.instr[INSTR_WIDTH-7:6];

  logic is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_andi, is_ori, is_slti, is_j;
  always_comb begin
    is_r    = (op == OP_RTYPE) && (funct inside {F_NOP, F_ADD, F_SUB, F_AND, F_OR, F_SLT});
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_beq  = (op == OP_BEQ);
    is_bne  = EXT && (op == OP_BNE);
    is_addi = (op == OP_ADDI);
    is_andi = EXT && (op == OP_ANDI);
    is_ori  = EXT && (op == OP_ORI);
    is_slti = EXT && (op == OP_SLTI);
    is_j    = (op == OP_J);
  end

  logic       mem_req, memwrite, iord, irwrite, pcen, alusrca, zeroext;
  logic       regwrite, regdst, memtoreg, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alu3;

  always_comb begin
    state_n  = state;
    mem_req  = 1'b0; memwrite = 1'b0; iord    = 1'b0; irwrite  = 1'b0;
    pcen     = 1'b0; pcsrc    = 2'b00; alusrca = 1'b0; alusrcb  = 2'b00;
    zeroext  = 1'b0; regwrite = 1'b0; regdst  = 1'b0; memtoreg = 1'b0;
    alu3     = 3'b010; illegal = 1'b0;
    mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    tmo = (MEM_TIMEOUT > 0) && mem_state && !bus.mem_ready && (wait_cnt == CNT_LAST);

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = bus.mem_ready;
        pcen    = bus.mem_ready;
        if (bus.mem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (is_r)                                     state_n = S_EXEC;
        else if (is_lw || is_sw)                      state_n = S_MEMADR;
        else if (is_beq || is_bne)                    state_n = S_BRANCH;
        else if (is_addi || is_andi || is_ori || is_slti) state_n = S_IEXEC;
        else if (is_j)                                state_n = S_JUMP;
        else                                          state_n = S_ILLEGAL;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_n = is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_n  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_n = S_FETCH;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        alu3    = r_alu(funct);
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_n  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        alu3    = 3'b110;
        pcsrc   = 2'b01;
        pcen    = is_bne ? ~bus.zero : bus.zero;
        state_n = S_FETCH;
      end
      // Immediate op and extension mode are held through write-back.
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zeroext = is_andi || is_ori;
        alu3    = i_alu(op);
        state_n = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        zeroext  = is_andi || is_ori;
        alu3     = i_alu(op);
        state_n  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_n = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase

    if (tmo) state_n = S_FETCH;
  end

  // Counter restarts on every state change and on a timeout retry of FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= tmo;
      if (tmo || (state_n != state))      wait_cnt <= '0;
      else if (mem_state && !bus.mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  logic live;
  assign live = ~rst;

  assign bus.mem_req    = mem_req  & live;
  assign bus.memwrite   = memwrite & live;
  assign bus.iord       = iord     & live;
  assign bus.irwrite    = irwrite  & live;
  assign bus.pcen       = pcen     & live;
  assign bus.pcsrc      = live ? pcsrc   : 2'b00;
  assign bus.alusrca    = alusrca  & live;
  assign bus.alusrcb    = live ? alusrcb : 2'b00;
  assign bus.zeroext    = zeroext  & live;
  assign bus.regwrite   = regwrite & live;
  assign bus.regdst     = regdst   & live;
  assign bus.memtoreg   = memtoreg & live;
  assign bus.alucontrol = live ? ALU_CTRL_WIDTH'(alu3) : '0;
  assign bus.illegal    = illegal  & live;
  assign bus.mem_err    = err_q    & live;

endmodule
